dbus_interconnect: RTL and testbench

//  Parametrised data-bus address decoder/router between the CPU data port and NREGIONS slaves.

---
 rtl/dbus_interconnect.sv | 155 +++++++++++++++
 tb/tb_dbus_interconnect.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dbus_interconnect.sv
// dbus_interconnect: data-bus address decoder/router between the CPU data
// port and NREGIONS slaves. Writes are routed combinationally by address.
// Read data is selected one cycle after the address. Unmapped accesses return
// ERR_DATA, are captured in sticky fault registers and raise fault_irq.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   dread_addr/en     CPU read address; the strobe is used only for faults
//   dread_data        read data, valid the cycle after dread_addr
//   dwrite_addr/data  CPU write address and data
//   dwrite_en         CPU byte write enables
//   s_dwrite_en       per-region byte enables (slice i -> region i)
//   s_dwrite_data     write data broadcast to all regions
//   s_dread_data      per-region read data (slice i from region i)
//   fault_clear       clears fault_valid and fault_count
//   fault_valid/addr/is_write/count/irq  sticky unmapped-access capture
module dbus_interconnect #(
  parameter int unsigned NREGIONS = 4,
  parameter int unsigned ADDRW    = 16,
  parameter int unsigned DATAW    = 16,
  parameter logic [NREGIONS*ADDRW-1:0] REGION_BASE  = {16'h2000, 16'h1000, 16'h0100, 16'h0000},
  parameter logic [NREGIONS*ADDRW-1:0] REGION_LIMIT = {16'hffff, 16'h1fff, 16'h01ff, 16'h00ff},
  parameter logic [DATAW-1:0]          ERR_DATA     = 16'hffff
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDRW-1:0]               dread_addr,
  input  logic                           dread_en,
  output logic [DATAW-1:0]               dread_data,
  input  logic [ADDRW-1:0]               dwrite_addr,
  input  logic [DATAW-1:0]               dwrite_data,
  input  logic [DATAW/8-1:0]             dwrite_en,
  output logic [NREGIONS*(DATAW/8)-1:0]  s_dwrite_en,
  output logic [DATAW-1:0]               s_dwrite_data,
  input  logic [NREGIONS*DATAW-1:0]      s_dread_data,
  input  logic                           fault_clear,
  output logic                           fault_valid,
  output logic [ADDRW-1:0]               fault_addr,
  output logic                           fault_is_write,
  output logic [7:0]                     fault_count,
  output logic                           fault_irq
);

  localparam int unsigned BEW  = DATAW / 8;
  // Three index bits cover the 1..8 region range; the MSB of a decode is the miss flag.
  localparam int unsigned IDXW = 3;
  localparam int unsigned SELW = IDXW + 1;

  if (NREGIONS < 1 || NREGIONS > 8 || (DATAW % 8) != 0) begin : g_param_check
    $error("dbus_interconnect: NREGIONS must be 1..8 and DATAW a multiple of 8");
  end

  // Address decode: {miss, index}; scanning downward lets the lowest index win overlaps.
  function automatic logic [SELW-1:0] decode(input logic [ADDRW-1:0] a);
    logic            hit;
    logic [IDXW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = int'(NREGIONS) - 1; i >= 0; i--) begin
      if (a >= REGION_BASE[i*ADDRW +: ADDRW] && a <= REGION_LIMIT[i*ADDRW +: ADDRW]) begin
        hit = 1'b1;
        idx = IDXW'(i);
      end
    end
    return {~hit, idx};
  endfunction

  logic [SELW-1:0] wr_sel;
  logic [SELW-1:0] rd_sel;
  logic            wr_miss;
  logic            rd_miss;

  assign wr_sel  = decode(dwrite_addr);
  assign rd_sel  = decode(dread_addr);
  assign wr_miss = (|dwrite_en) & wr_sel[IDXW];
  assign rd_miss = dread_en & rd_sel[IDXW];

  // Write routing: enables go only to the winning region, none on a miss.
  always_comb begin
    s_dwrite_en = '0;
    for (int i = 0; i < int'(NREGIONS); i++) begin
      if (!wr_sel[IDXW] && wr_sel[IDXW-1:0] == IDXW'(i)) begin
        s_dwrite_en[i*BEW +: BEW] = dwrite_en;
      end
    end
  end

  assign s_dwrite_data = dwrite_data;

  // Read select register, loaded every cycle regardless of dread_en.
  logic [SELW-1:0] sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= {1'b1, IDXW'(0)};
    end else begin
      sel_q <= rd_sel;
    end
  end

  // Read return mux driven from the registered select.
  always_comb begin
    dread_data = ERR_DATA;
    for (int i = 0; i < int'(NREGIONS); i++) begin
      if (!sel_q[IDXW] && sel_q[IDXW-1:0] == IDXW'(i)) begin
        dread_data = s_dread_data[i*DATAW +: DATAW];
      end
    end
  end

  // Fault capture: clear applies first, then this cycle's events.
  logic             fault_valid_q, fault_valid_d;
  logic [ADDRW-1:0] fault_addr_q, fault_addr_d;
  logic             fault_is_write_q, fault_is_write_d;
  logic [7:0]       fault_count_q, fault_count_d;
  logic [7:0]       cnt_base;
  logic [8:0]       cnt_sum;

  always_comb begin
    fault_valid_d    = (fault_valid_q & ~fault_clear) | rd_miss | wr_miss;
    fault_addr_d     = fault_addr_q;
    fault_is_write_d = fault_is_write_q;
    if (wr_miss) begin
      fault_addr_d     = dwrite_addr;
      fault_is_write_d = 1'b1;
    end else if (rd_miss) begin
      fault_addr_d     = dread_addr;
      fault_is_write_d = 1'b0;
    end
    cnt_base      = fault_clear ? 8'd0 : fault_count_q;
    cnt_sum       = 9'(cnt_base) + 9'(rd_miss) + 9'(wr_miss);
    fault_count_d = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid_q    <= 1'b0;
      fault_addr_q     <= '0;
      fault_is_write_q <= 1'b0;
      fault_count_q    <= 8'd0;
    end else begin
      fault_valid_q    <= fault_valid_d;
      fault_addr_q     <= fault_addr_d;
      fault_is_write_q <= fault_is_write_d;
      fault_count_q    <= fault_count_d;
    end
  end

  assign fault_valid    = fault_valid_q;
  assign fault_addr     = fault_addr_q;
  assign fault_is_write = fault_is_write_q;
  assign fault_count    = fault_count_q;
  assign fault_irq      = fault_valid_q;

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed bench for dbus_interconnect: default build plus an overlapping-region build.
module tb_dbus_interconnect;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dread_addr;
  logic        dread_en;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic [1:0]  dwrite_en;
  logic [63:0] s_dread_data;
  logic        fault_clear;

  logic [15:0] dread_data,  ov_dread_data;
  logic [7:0]  s_dwrite_en, ov_s_dwrite_en;
  logic [15:0] s_dwrite_data, ov_s_dwrite_data;
  logic        fault_valid, ov_fault_valid;
  logic [15:0] fault_addr, ov_fault_addr;
  logic        fault_is_write, ov_fault_is_write;
  logic [7:0]  fault_count, ov_fault_count;
  logic        fault_irq, ov_fault_irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbus_interconnect dut (
    .clk(clk), .reset(reset),
    .dread_addr(dread_addr), .dread_en(dread_en), .dread_data(dread_data),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
    .s_dwrite_en(s_dwrite_en), .s_dwrite_data(s_dwrite_data), .s_dread_data(s_dread_data),
    .fault_clear(fault_clear), .fault_valid(fault_valid), .fault_addr(fault_addr),
    .fault_is_write(fault_is_write), .fault_count(fault_count), .fault_irq(fault_irq)
  );

  // Region 1 overlaps region 0 completely.
  dbus_interconnect #(
    .REGION_BASE ({16'h2000, 16'h1000, 16'h0000, 16'h0000}),
    .REGION_LIMIT({16'hffff, 16'h1fff, 16'h00ff, 16'h00ff})
  ) dut_ov (
    .clk(clk), .reset(reset),
    .dread_addr(dread_addr), .dread_en(dread_en), .dread_data(ov_dread_data),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
    .s_dwrite_en(ov_s_dwrite_en), .s_dwrite_data(ov_s_dwrite_data), .s_dread_data(s_dread_data),
    .fault_clear(fault_clear), .fault_valid(ov_fault_valid), .fault_addr(ov_fault_addr),
    .fault_is_write(ov_fault_is_write), .fault_count(ov_fault_count), .fault_irq(ov_fault_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    dread_addr   = 16'h0000;
    dread_en     = 1'b0;
    dwrite_addr  = 16'h0000;
    dwrite_data  = 16'h0000;
    dwrite_en    = 2'b00;
    fault_clear  = 1'b0;
    s_dread_data = {16'hd333, 16'hc222, 16'hb111, 16'ha000};

    tick();
    tick();
    check("reset_rdata", 32'(dread_data), 32'h0000ffff);
    check("reset_valid", 32'(fault_valid), 32'd0);
    check("reset_irq",   32'(fault_irq), 32'd0);
    check("reset_addr",  32'(fault_addr), 32'd0);
    check("reset_iswr",  32'(fault_is_write), 32'd0);
    check("reset_count", 32'(fault_count), 32'd0);
    reset = 1'b0;

    // Write hit on region 3 and read of the same address.
    dwrite_addr = 16'h2004;
    dwrite_data = 16'hbeef;
    dwrite_en   = 2'b11;
    dread_addr  = 16'h2004;
    #1;
    check("wr_r3_en",   32'(s_dwrite_en), 32'h000000c0);
    check("wr_data",    32'(s_dwrite_data), 32'h0000beef);
    tick();
    check("rd_r3_data", 32'(dread_data), 32'h0000d333);
    dwrite_addr = 16'h0150;
    dwrite_en   = 2'b01;
    #1;
    check("wr_r1_en",   32'(s_dwrite_en), 32'h00000004);
    dwrite_en = 2'b00;
    #1;
    check("wr_idle_en", 32'(s_dwrite_en), 32'h00000000);

    // Back-to-back reads, each lagging its address by one cycle.
    dread_addr = 16'h0050;
    tick();
    check("rd_r0_data", 32'(dread_data), 32'h0000a000);
    dread_addr = 16'h1800;
    #1;
    check("rd_lag",     32'(dread_data), 32'h0000a000);
    tick();
    check("rd_r2_data", 32'(dread_data), 32'h0000c222);
    check("no_fault",   32'(fault_valid), 32'd0);

    // Unmapped read.
    dread_addr = 16'h0300;
    dread_en   = 1'b1;
    tick();
    check("rmiss_data",  32'(dread_data), 32'h0000ffff);
    check("rmiss_valid", 32'(fault_valid), 32'd1);
    check("rmiss_irq",   32'(fault_irq), 32'd1);
    check("rmiss_addr",  32'(fault_addr), 32'h00000300);
    check("rmiss_iswr",  32'(fault_is_write), 32'd0);
    check("rmiss_count", 32'(fault_count), 32'd1);

    // Simultaneous write miss and read miss: write wins capture, count += 2.
    dwrite_addr = 16'h0400;
    dwrite_en   = 2'b11;
    dread_addr  = 16'h0500;
    #1;
    check("wmiss_en", 32'(s_dwrite_en), 32'h00000000);
    tick();
    check("both_addr",  32'(fault_addr), 32'h00000400);
    check("both_iswr",  32'(fault_is_write), 32'd1);
    check("both_count", 32'(fault_count), 32'd3);
    dwrite_en = 2'b00;

    // 300 unmapped reads saturate the counter.
    dread_addr = 16'h0300;
    repeat (252) tick();
    check("count_255", 32'(fault_count), 32'h000000ff);
    repeat (48) tick();
    check("count_sat", 32'(fault_count), 32'h000000ff);

    // Clear together with a new miss.
    fault_clear = 1'b1;
    tick();
    check("clr_ev_valid", 32'(fault_valid), 32'd1);
    check("clr_ev_count", 32'(fault_count), 32'd1);
    dread_en = 1'b0;
    tick();
    check("clr_valid", 32'(fault_valid), 32'd0);
    check("clr_count", 32'(fault_count), 32'd0);
    check("clr_addr",  32'(fault_addr), 32'h00000300);
    check("clr_iswr",  32'(fault_is_write), 32'd0);
    fault_clear = 1'b0;

    // Overlap: region 0 wins in the overlapping build.
    dread_addr  = 16'h0080;
    dwrite_addr = 16'h0080;
    dwrite_en   = 2'b11;
    #1;
    check("ov_wr_en", 32'(ov_s_dwrite_en), 32'h00000003);
    tick();
    check("ov_rd_data", 32'(ov_dread_data), 32'h0000a000);
    dwrite_en = 2'b00;

    // Reset mid-read discards the pending select and the fault state.
    dread_addr = 16'h0300;
    dread_en   = 1'b1;
    tick();
    check("pre_rst_valid", 32'(fault_valid), 32'd1);
    dread_addr  = 16'h2004;
    dread_en    = 1'b0;
    reset       = 1'b1;
    dwrite_addr = 16'h2004;
    dwrite_en   = 2'b01;
    #1;
    check("rst_wr_en", 32'(s_dwrite_en), 32'h00000040);
    tick();
    check("rst_rdata", 32'(dread_data), 32'h0000ffff);
    check("rst_valid", 32'(fault_valid), 32'd0);
    check("rst_irq",   32'(fault_irq), 32'd0);
    check("rst_addr",  32'(fault_addr), 32'd0);
    check("rst_count", 32'(fault_count), 32'd0);
    dwrite_en = 2'b00;
    reset     = 1'b0;
    tick();
    check("post_rst_rdata", 32'(dread_data), 32'h0000d333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
